// File: rtl/shift_register_framed_pkg.sv
`default_nettype none
// ============================================================================
// Module  : periph_pkg
// Brief   : Shared bit-order modes and controller states for the framed
//           peripheral shift register.
// Rev     : 1.0
// ============================================================================
package periph_pkg;

    localparam logic MODE_MSB_FIRST = 1'b0;
    localparam logic MODE_LSB_FIRST = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage : periph_pkg
`default_nettype wire

// File: rtl/shift_register_framed_if.sv
`default_nettype none
// ============================================================================
// Module  : shift_register_framed_if
// Brief   : Control, serial and parallel data bundle of the framed shifter.
// Rev     : 1.0
// ============================================================================
interface shift_register_framed_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH);

    logic             enable;
    logic             peripheralClkEdge;
    logic             lsbFirst;
    logic             parallelLoad;
    logic [WIDTH-1:0] parallelDataIn;
    logic             serialDataIn;
    logic             serialDataOut;
    logic [WIDTH-1:0] parallelDataOut;
    logic [WIDTH-1:0] shiftDataOut;
    logic             wordValid;
    logic [CNT_W-1:0] bitCount;
    logic             busy;

    modport master (
        output enable, peripheralClkEdge, lsbFirst, parallelLoad,
               parallelDataIn, serialDataIn,
        input  serialDataOut, parallelDataOut, shiftDataOut, wordValid,
               bitCount, busy
    );

    modport slave (
        input  enable, peripheralClkEdge, lsbFirst, parallelLoad,
               parallelDataIn, serialDataIn,
        output serialDataOut, parallelDataOut, shiftDataOut, wordValid,
               bitCount, busy
    );

endinterface : shift_register_framed_if
`default_nettype wire

// File: rtl/shift_register_framed_bit_counter.sv
`default_nettype none
// ============================================================================
// Module  : shift_bit_counter
// Brief   : Wrapping bit counter for one word; flags the final bit position.
// Rev     : 1.0
// ============================================================================
module shift_bit_counter #(
    parameter int WIDTH = 8
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_clear,
    input  wire logic                     i_advance,
    output logic [$clog2(WIDTH)-1:0]      o_count,
    output logic                          o_last
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0] r_count;

    assign o_count = r_count;
    assign o_last  = (r_count == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_advance) begin
            r_count <= o_last ? '0 : r_count + CNT_W'(1);
        end
    end

endmodule : shift_bit_counter
`default_nettype wire

// File: rtl/shift_register_framed.sv
`default_nettype none
// ============================================================================
// Module  : shift_register_framed
// Brief   : Framed serial/parallel shift register with selectable bit order,
//           word counter and held receive word.
// Rev     : 1.0
// ============================================================================
module shift_register_framed
    import periph_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic               clk,
    input  wire logic               reset,
    shift_register_framed_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    state_t           w_state;
    logic             w_shift_en;
    logic             w_complete;
    logic             w_last;
    logic             w_clear;
    logic             w_mode_capture;
    logic [CNT_W-1:0] w_count;
    logic [WIDTH-1:0] w_shifted;

    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_hold;
    logic             r_valid;
    logic             r_mode;

    assign w_state    = bus.enable ? ST_SHIFT : ST_IDLE;
    assign w_shift_en = (w_state == ST_SHIFT) && bus.peripheralClkEdge;
    assign w_complete = w_shift_en && w_last;
    assign w_clear    = (w_state == ST_IDLE) || bus.parallelLoad;

    // The first strobe of a word shifts with the already latched mode, so the
    // mode is not re-sampled on that cycle.
    assign w_mode_capture = bus.parallelLoad || (w_state == ST_IDLE) ||
                            ((w_count == '0) && !bus.peripheralClkEdge);

    assign w_shifted = (r_mode == MODE_LSB_FIRST) ?
                       {bus.serialDataIn, r_sr[WIDTH-1:1]} :
                       {r_sr[WIDTH-2:0], bus.serialDataIn};

    shift_bit_counter #(
        .WIDTH     (WIDTH)
    ) u_bit_counter (
        .clk       (clk),
        .rst       (reset),
        .i_clear   (w_clear),
        .i_advance (w_shift_en),
        .o_count   (w_count),
        .o_last    (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr    <= '0;
            r_hold  <= '0;
            r_valid <= 1'b0;
            r_mode  <= MODE_MSB_FIRST;
        end else begin
            r_valid <= w_complete;
            if (w_complete) begin
                r_hold <= w_shifted;
            end
            // A load always wins the register; a completing strobe has
            // already handed its word to the hold register above.
            if (bus.parallelLoad) begin
                r_sr <= bus.parallelDataIn;
            end else if (w_shift_en) begin
                r_sr <= w_shifted;
            end
            if (w_mode_capture) begin
                r_mode <= bus.lsbFirst;
            end
        end
    end

    assign bus.serialDataOut   = (r_mode == MODE_LSB_FIRST) ? r_sr[0] : r_sr[WIDTH-1];
    assign bus.parallelDataOut = r_hold;
    assign bus.shiftDataOut    = r_sr;
    assign bus.wordValid       = r_valid;
    assign bus.bitCount        = w_count;
    assign bus.busy            = (w_count != '0);

endmodule : shift_register_framed
`default_nettype wire

// File: tb/tb_shift_register_framed.sv
`default_nettype none
// ============================================================================
// Module  : tb_shift_register_framed
// Brief   : Directed self-checking bench for 8- and 16-bit framed shifters.
// Rev     : 1.0
// ============================================================================
module tb_shift_register_framed;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    shift_register_framed_if #(.WIDTH(8))  b8 ();
    shift_register_framed_if #(.WIDTH(16)) b16 ();

    shift_register_framed #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (b8)
    );

    shift_register_framed #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (b16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step8(input logic en, input logic st, input logic si,
                         input logic ld, input logic [7:0] d);
        b8.enable            = en;
        b8.peripheralClkEdge = st;
        b8.serialDataIn      = si;
        b8.parallelLoad      = ld;
        b8.parallelDataIn    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic step16(input logic st, input logic si);
        b16.enable            = 1'b1;
        b16.peripheralClkEdge = st;
        b16.serialDataIn      = si;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  v8;
        logic [15:0] v16;

        reset = 1'b1;
        b8.enable = 0; b8.peripheralClkEdge = 0; b8.lsbFirst = 0;
        b8.parallelLoad = 0; b8.parallelDataIn = '0; b8.serialDataIn = 0;
        b16.enable = 0; b16.peripheralClkEdge = 0; b16.lsbFirst = 0;
        b16.parallelLoad = 0; b16.parallelDataIn = '0; b16.serialDataIn = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pdo",   32'(b8.parallelDataOut), 32'h0);
        chk("rst_sdo",   32'(b8.shiftDataOut),    32'h0);
        chk("rst_valid", 32'(b8.wordValid),       32'h0);
        chk("rst_cnt",   32'(b8.bitCount),        32'h0);
        chk("rst_busy",  32'(b8.busy),            32'h0);
        chk("rst_sout",  32'(b8.serialDataOut),   32'h0);
        reset = 1'b0;
        step8(1, 0, 0, 0, 8'h00);

        // Receive 0xA5 MSB-first
        v8 = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            step8(1, 1, v8[7-i], 0, 8'h00);
            chk("a5_valid", 32'(b8.wordValid), (i == 7) ? 32'h1 : 32'h0);
            if (i == 2) chk("a5_cnt3", 32'(b8.bitCount), 32'h3);
            if (i == 2) chk("a5_busy", 32'(b8.busy), 32'h1);
        end
        chk("a5_pdo", 32'(b8.parallelDataOut), 32'hA5);
        chk("a5_cnt", 32'(b8.bitCount), 32'h0);
        step8(1, 0, 0, 0, 8'h00);
        chk("a5_valid_drop", 32'(b8.wordValid), 32'h0);
        chk("a5_pdo_held", 32'(b8.parallelDataOut), 32'hA5);

        // Transmit 0x3C MSB-first
        step8(1, 0, 0, 1, 8'h3C);
        v8 = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            chk("3c_sout", 32'(b8.serialDataOut), 32'(v8[7-i]));
            step8(1, 1, 0, 0, 8'h00);
        end
        chk("3c_sdo", 32'(b8.shiftDataOut), 32'h00);
        chk("3c_pdo", 32'(b8.parallelDataOut), 32'h00);

        // LSB-first with mid-word mode flip ignored
        b8.lsbFirst = 1'b1;
        step8(1, 0, 0, 1, 8'h01);
        v8 = 8'h03;
        for (int i = 0; i < 8; i++) begin
            chk("lsb_sout", 32'(b8.serialDataOut), (i == 0) ? 32'h1 : 32'h0);
            if (i == 2) b8.lsbFirst = 1'b0;
            step8(1, 1, v8[i], 0, 8'h00);
        end
        chk("lsb_pdo", 32'(b8.parallelDataOut), 32'h03);
        chk("lsb_valid", 32'(b8.wordValid), 32'h1);
        step8(1, 0, 0, 0, 8'h00);

        // Load on the completing strobe: back-to-back words
        for (int i = 0; i < 7; i++) step8(1, 1, 1, 0, 8'h00);
        step8(1, 1, 1, 1, 8'h96);
        chk("b2b_pdo",   32'(b8.parallelDataOut), 32'hFF);
        chk("b2b_valid", 32'(b8.wordValid),       32'h1);
        chk("b2b_sdo",   32'(b8.shiftDataOut),    32'h96);
        chk("b2b_cnt",   32'(b8.bitCount),        32'h0);

        // Load on a non-completing strobe discards the partial word
        for (int i = 0; i < 3; i++) step8(1, 1, 1, 0, 8'h00);
        step8(1, 1, 1, 1, 8'h55);
        chk("ldmid_cnt",   32'(b8.bitCount),     32'h0);
        chk("ldmid_sdo",   32'(b8.shiftDataOut), 32'h55);
        chk("ldmid_valid", 32'(b8.wordValid),    32'h0);

        // Enable drop after 3 strobes aborts the word; strobe ignored
        for (int i = 0; i < 3; i++) step8(1, 1, 0, 0, 8'h00);
        chk("abort_cnt3", 32'(b8.bitCount), 32'h3);
        step8(0, 1, 1, 0, 8'h00);
        chk("abort_cnt",   32'(b8.bitCount),        32'h0);
        chk("abort_valid", 32'(b8.wordValid),       32'h0);
        chk("abort_pdo",   32'(b8.parallelDataOut), 32'hFF);
        chk("abort_sdo",   32'(b8.shiftDataOut),    32'hA8);
        step8(0, 0, 0, 1, 8'h12);
        chk("preload_sdo", 32'(b8.shiftDataOut), 32'h12);
        chk("preload_cnt", 32'(b8.bitCount),     32'h0);

        // Reset after 5 strobes
        for (int i = 0; i < 5; i++) step8(1, 1, 1, 0, 8'h00);
        chk("rstmid_cnt5", 32'(b8.bitCount), 32'h5);
        reset = 1'b1;
        step8(1, 1, 1, 0, 8'h00);
        reset = 1'b0;
        chk("rstmid_cnt",   32'(b8.bitCount),        32'h0);
        chk("rstmid_valid", 32'(b8.wordValid),       32'h0);
        chk("rstmid_pdo",   32'(b8.parallelDataOut), 32'h00);
        chk("rstmid_sdo",   32'(b8.shiftDataOut),    32'h00);
        step8(0, 0, 0, 0, 8'h00);

        // 16-bit build: 0xBEEF MSB-first
        step16(0, 0);
        v16 = 16'hBEEF;
        for (int i = 0; i < 16; i++) begin
            step16(1, v16[15-i]);
            chk("w16_valid", 32'(b16.wordValid), (i == 15) ? 32'h1 : 32'h0);
            if (i == 14) chk("w16_cnt15", 32'(b16.bitCount), 32'hF);
        end
        chk("w16_pdo", 32'(b16.parallelDataOut), 32'hBEEF);
        chk("w16_cnt", 32'(b16.bitCount), 32'h0);
        step16(0, 0);
        chk("w16_valid_drop", 32'(b16.wordValid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_shift_register_framed
`default_nettype wire

// File: doc/shift_register_framed.md
Name: shift_register_framed

Overview:
Parametrised serial/parallel shift register for the peripheral (SPI-style) datapath, clocked entirely on clk. The peripheral clock is seen only as single-cycle edge strobes, which act as clock enables. Over the plain shift register it adds:
- selectable MSB-first or LSB-first order
- an enable/frame input
- a bit counter with a word-complete pulse
- a held receive word, so the parallel output stays stable while the next word shifts
- defined priority between load, shift and frame events

Parameters:
WIDTH, 8, word length in bits (legal range 2..32)
CNT_W, $clog2(WIDTH), bit counter width (derived; do not override)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  frame active; low aborts the current word and ignores strobes
peripheralClkEdge  input  1  one-clk-wide strobe: shift one bit this cycle
lsbFirst  input  1  0 = MSB-first, 1 = LSB-first; latched at word start only
parallelLoad  input  1  load parallelDataIn into the shift register this cycle
parallelDataIn  input  WIDTH  word to transmit
serialDataIn  input  1  receive bit, sampled on strobe cycles
serialDataOut  output  1  current transmit bit
parallelDataOut  output  WIDTH  last completed received word (held)
shiftDataOut  output  WIDTH  live shift register contents
wordValid  output  1  one-clk pulse: parallelDataOut just updated
bitCount  output  CNT_W  bits shifted in the current word
busy  output  1  high when bitCount != 0

Behaviour:
- Reset values (applied on clk when reset=1; overrides all other inputs): shift register 0, parallelDataOut 0, wordValid 0, bitCount 0, latched mode 0 (MSB-first). Hence serialDataOut 0 and busy 0.
- serialDataOut is combinational from the register and latched mode: mode=0 gives sr[WIDTH-1]; mode=1 gives sr[0].
- Shift step (enable=1, strobe=1):
  - MSB-first: sr <= {sr[WIDTH-2:0], serialDataIn}
  - LSB-first: sr <= {serialDataIn, sr[WIDTH-1:1]}
  - Effect is visible the clk after the strobe cycle.
- Bit counter:
  - increments on each accepted strobe.
  - On the strobe where bitCount == WIDTH-1, the word completes:
    - parallelDataOut <= shifted value
    - wordValid = 1 for exactly one clk following that edge
    - bitCount wraps to 0
- Mode latch: lsbFirst is captured whenever bitCount == 0, on load cycles and on idle cycles. Changes in lsbFirst mid-word are ignored.
- Per-cycle priority: reset > enable low > parallelLoad > strobe.
- enable=0:
  - bitCount <= 0 and strobes are ignored.
  - The shift register holds, except that parallelLoad is still honoured, so a word can be preloaded before the frame.
  - No wordValid for a partial word.
- parallelLoad=1 together with a non-completing strobe: the load wins, the partial word is discarded, bitCount <= 0, and the strobe is dropped.
- parallelLoad=1 together with the completing strobe: both actions happen, which gives back-to-back words with no gap.
  - parallelDataOut captures the fully shifted word and wordValid pulses.
  - The shift register then takes parallelDataIn and bitCount <= 0.
- Strobes are assumed at most one per clk. A strobe held high for N clks counts as N shifts, with no edge detection inside the block.
- Reset mid-word: all state returns to reset values on the next clk and no wordValid is generated.
- Controller states: IDLE (enable=0), SHIFT (enable=1, bitCount 0..WIDTH-1). The word-complete transition is SHIFT -> SHIFT with the count wrapping to 0.

Decomposition:
- Shared package periph_pkg holds:
  - MODE_MSB_FIRST = 1'b0 and MODE_LSB_FIRST = 1'b1
  - the state enum {ST_IDLE, ST_SHIFT}
- One natural sub-module, shift_bit_counter (parameter WIDTH):
  - inputs: clear, advance
  - outputs: count, last (count == WIDTH-1)
- The shift datapath and the hold register stay in the top module.

Test Plan:
- WIDTH=8, MSB-first, enable=1, serial bits 1,0,1,0,0,1,0,1 on 8 strobes -> parallelDataOut=0xA5; exactly one wordValid pulse, after the 8th strobe; bitCount back to 0.
- Load 0x3C, MSB-first, 8 strobes with serialDataIn=0 -> serialDataOut sequence 0,0,1,1,1,1,0,0; shiftDataOut=0x00 at end.
- Load 0x01, set lsbFirst=1 at load, then flip lsbFirst to 0 after 2 strobes -> serialDataOut sequence 1,0,0,0,0,0,0,0 (mode held); serial bits 1,1,0,0,0,0,0,0 -> parallelDataOut=0x03.
- parallelLoad=0x96 on the same clk as the 8th strobe of serial word 0xFF -> parallelDataOut=0xFF and wordValid pulses; shiftDataOut=0x96; bitCount=0.
- Drop enable after 3 strobes, or assert reset after 5 -> bitCount=0, no wordValid, parallelDataOut unchanged (0x00 after reset).
- WIDTH=16 build, 16 strobes shifting 0xBEEF MSB-first -> parallelDataOut=0xBEEF; wordValid pulses once; no pulse after 15 strobes.
